// File: rtl/register_sync_arbiter.sv
// Round-robin arbiter sharing one register-synchronizer channel among NUM_REQ requesters.
// Launches one transfer at a time and reports completion or timeout abort to the owner.
module register_sync_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 16,
  parameter  int TIMEOUT = 1024,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic                     sync_en,
  output logic [WIDTH-1:0]         sync_data,
  output logic [ID_W-1:0]          sync_id,
  input  logic                     sync_ack,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     busy
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } state_t;

  // Round-robin pick: lowest offset k in 1..NUM_REQ from last grant wins.
  function automatic logic [ID_W:0] f_rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int            c;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(last) + k) % NUM_REQ;
      if (r[c]) res = {1'b1, ID_W'(c)};
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] f_slice(input logic [NUM_REQ*WIDTH-1:0] d,
                                               input logic [ID_W-1:0]          idx);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == idx) res = d[j*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  state_t               r_state;
  logic                 r_sync_en;
  logic [WIDTH-1:0]     r_sync_data;
  logic [ID_W-1:0]      r_sync_id;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_err;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt;
  logic [ID_W-1:0]      r_last;

  state_t               w_nxt_state;
  logic                 w_nxt_en;
  logic [WIDTH-1:0]     w_nxt_data;
  logic [ID_W-1:0]      w_nxt_id;
  logic [NUM_REQ-1:0]   w_nxt_done;
  logic                 w_nxt_err;
  logic [CNT_W-1:0]     w_nxt_cnt;
  logic [ID_W-1:0]      w_nxt_last;
  logic [NUM_REQ-1:0]   w_req_elig;
  logic [ID_W:0]        w_pick;
  logic [WIDTH-1:0]     w_win_data;

  // The owner finishing this cycle is masked so a held req is not re-granted at once.
  assign w_req_elig = req & ~r_done;
  assign w_pick     = f_rr_pick(w_req_elig, r_last);
  assign w_win_data = f_slice(req_data, w_pick[ID_W-1:0]);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_en    = 1'b0;
    w_nxt_data  = r_sync_data;
    w_nxt_id    = r_sync_id;
    w_nxt_done  = '0;
    w_nxt_err   = 1'b0;
    w_nxt_cnt   = r_cnt;
    w_nxt_last  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_pick[ID_W]) begin
          w_nxt_state = S_WAIT_ACK;
          w_nxt_en    = 1'b1;
          w_nxt_data  = w_win_data;
          w_nxt_id    = w_pick[ID_W-1:0];
          w_nxt_last  = w_pick[ID_W-1:0];
          w_nxt_cnt   = '0;
        end
      end
      S_WAIT_ACK: begin
        // Ack takes precedence over a coincident timeout.
        if (sync_ack) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = NUM_REQ'(1) << r_sync_id;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = NUM_REQ'(1) << r_sync_id;
          w_nxt_err   = 1'b1;
        end else begin
          w_nxt_cnt   = r_cnt + CNT_W'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync_en   <= 1'b0;
      r_sync_data <= '0;
      r_sync_id   <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_last      <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state     <= w_nxt_state;
      r_sync_en   <= w_nxt_en;
      r_sync_data <= w_nxt_data;
      r_sync_id   <= w_nxt_id;
      r_done      <= w_nxt_done;
      r_err       <= w_nxt_err;
      r_busy      <= (w_nxt_state != S_IDLE);
      r_cnt       <= w_nxt_cnt;
      r_last      <= w_nxt_last;
    end
  end

  assign sync_en   = r_sync_en;
  assign sync_data = r_sync_data;
  assign sync_id   = r_sync_id;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_register_sync_arbiter.sv
// Scenario tasks plus a randomized run against a transaction-level arbiter model.
module tb_register_sync_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           sync_en;
  logic [W-1:0]   sync_data;
  logic [IW-1:0]  sync_id;
  logic           sync_ack;
  logic [N-1:0]   done;
  logic           err;
  logic           busy;

  logic [24:0]    obs;
  int             n_checks = 0;
  int             n_fail   = 0;

  register_sync_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .sync_en(sync_en), .sync_data(sync_data), .sync_id(sync_id),
    .sync_ack(sync_ack), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // {sync_en, sync_data, sync_id, done, err, busy}
  assign obs = {sync_en, sync_data, sync_id, done, err, busy};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; sync_ack = 1'b0; req_data = '0;
    step(); step();
    n_checks++;
    if (obs !== 25'h0) begin
      n_fail++; $display("FAIL reset: got %h expected %h", obs, 25'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_data(2, 16'hBEEF); req = 4'b0100;
    step();
    n_checks++;
    if (obs !== {1'b1, 16'hBEEF, 2'd2, 4'b0000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL single_launch: got %h", obs);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (obs !== {1'b0, 16'hBEEF, 2'd2, 4'b0000, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL single_wait%0d: got %h", i, obs);
      end
    end
    sync_ack = 1'b1;
    step();
    n_checks++;
    if (obs !== {1'b0, 16'hBEEF, 2'd2, 4'b0100, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_done: got %h expected done=0100 err=0 busy=0", obs);
    end
    sync_ack = 1'b0; req = '0;
    step();
    n_checks++;
    if (obs !== {1'b0, 16'hBEEF, 2'd2, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_idle: got %h", obs);
    end
  endtask

  task automatic test_contention();
    int id;
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 16'hA000 + 16'(i));
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      id = k % N;
      n_checks++;
      if (obs !== {1'b1, 16'hA000 + 16'(id), 2'(id), 4'b0000, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL contention_launch%0d: got %h expected id %0d", k, obs, id);
      end
      sync_ack = 1'b1;
      step();
      sync_ack = 1'b0;
      n_checks++;
      if (obs !== {1'b0, 16'hA000 + 16'(id), 2'(id), 4'(1 << id), 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL contention_done%0d: got %h expected id %0d", k, obs, id);
      end
      step();
    end
    n_checks++;
    if (obs !== {1'b1, 16'hA001, 2'd1, 4'b0000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL contention_launch5: got %h expected id 1", obs);
    end
    req = '0; sync_ack = 1'b1;
    step();
    sync_ack = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    set_data(1, 16'h1111); req = 4'b0010;
    step();
    n_checks++;
    if (obs !== {1'b1, 16'h1111, 2'd1, 4'b0000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_launch: got %h", obs);
    end
    for (int i = 1; i < TO; i++) begin
      step();
      n_checks++;
      if (obs !== {1'b0, 16'h1111, 2'd1, 4'b0000, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL timeout_wait%0d: got %h", i, obs);
      end
    end
    step();
    n_checks++;
    if (obs !== {1'b0, 16'h1111, 2'd1, 4'b0010, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL timeout_done: got %h expected done=0010 err=1", obs);
    end
    // req[1] still high in its own done cycle: no relaunch until the cycle after.
    step();
    n_checks++;
    if (obs !== {1'b0, 16'h1111, 2'd1, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL done_cycle_mask: got %h expected idle", obs);
    end
    step();
    n_checks++;
    if (obs !== {1'b1, 16'h1111, 2'd1, 4'b0000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL relaunch_after_mask: got %h", obs);
    end
    sync_ack = 1'b1; req = '0;
    step();
    sync_ack = 1'b0;
    step();
  endtask

  task automatic test_race();
    set_data(0, 16'h5A5A); req = 4'b0001;
    step();
    for (int i = 1; i < TO; i++) step();
    sync_ack = 1'b1;
    step();
    sync_ack = 1'b0; req = '0;
    n_checks++;
    if (obs !== {1'b0, 16'h5A5A, 2'd0, 4'b0001, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL race_ack_wins: got %h expected done=0001 err=0", obs);
    end
    step();
  endtask

  task automatic test_data_hold();
    set_data(0, 16'h1234); req = 4'b0001;
    step(); step();
    set_data(0, 16'hABCD); req = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs !== {1'b0, 16'h1234, 2'd0, 4'b0000, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL data_hold%0d: got %h", i, obs);
      end
    end
    sync_ack = 1'b1;
    step();
    sync_ack = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 16'h1234, 2'd0, 4'b0001, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL data_hold_done: got %h", obs);
    end
    step();
  endtask

  task automatic test_reset_mid();
    set_data(2, 16'h7777); req = 4'b0100;
    step(); step();
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0;
    n_checks++;
    if (obs !== 25'h0) begin
      n_fail++; $display("FAIL reset_mid: got %h expected %h", obs, 25'h0);
    end
    sync_ack = 1'b1;
    step();
    sync_ack = 1'b0;
    n_checks++;
    if (obs !== 25'h0) begin
      n_fail++; $display("FAIL stray_ack: got %h expected %h", obs, 25'h0);
    end
    set_data(0, 16'h0C0C); req = 4'b1111;
    step();
    n_checks++;
    if (obs !== {1'b1, 16'h0C0C, 2'd0, 4'b0000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL post_reset_priority: got %h expected id 0", obs);
    end
    sync_ack = 1'b1; req = '0;
    step();
    sync_ack = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic          m_busy;
    int            m_owner, m_age, m_last, c;
    logic [W-1:0]  m_data;
    logic [N-1:0]  m_done_now, elig, n_done;
    logic          n_en, n_err;
    logic [24:0]   exp_v;
    rst = 1'b1; req = '0; sync_ack = 1'b0;
    step();
    rst = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_age = 0; m_last = N - 1;
    m_data = '0; m_done_now = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req      = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      req_data = {$urandom, $urandom};
      sync_ack = ($urandom_range(0, 5) == 0);
      n_en = 1'b0; n_err = 1'b0; n_done = '0;
      if (!m_busy) begin
        elig = req & ~m_done_now;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!n_en && elig[c]) begin
            n_en = 1'b1; m_busy = 1'b1; m_owner = c; m_age = 0; m_last = c;
            m_data = req_data[c*W +: W];
          end
        end
      end else if (sync_ack) begin
        n_done = N'(1 << m_owner); m_busy = 1'b0;
      end else if (m_age == TO - 1) begin
        n_done = N'(1 << m_owner); n_err = 1'b1; m_busy = 1'b0;
      end else begin
        m_age++;
      end
      exp_v = {n_en, m_data, IW'(m_owner), n_done, n_err, m_busy};
      m_done_now = n_done;
      step();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", cyc, obs, exp_v);
      end
    end
    req = '0; sync_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_race();
    test_data_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_sync_arbiter.md
REGISTER_SYNC_ARBITER -- requirements
Module: register_sync_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one register-synchronizer channel (legal range 2..16).
REQ-002 Parameter WIDTH, default 16, SHALL set the register payload width.
REQ-003 Parameter TIMEOUT, default 1024, SHALL set the max cycles spent waiting for ack before abort (legal range >= 4).
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester level request; held high until the matching done bit pulses.
REQ-007 req_data  input  NUM_REQ*WIDTH  per-requester payload; slice i = bits [i*WIDTH +: WIDTH].
REQ-008 sync_en  output  1  single-cycle launch pulse to the synchronizer enable input.
REQ-009 sync_data  output  WIDTH  payload to the synchronizer data input.
REQ-010 sync_id  output  $clog2(NUM_REQ)  index of the requester owning the current transfer.
REQ-011 sync_ack  input  1  single-cycle acknowledge pulse returned by the synchronizer.
REQ-012 done  output  NUM_REQ  one-hot single-cycle completion pulse to the owning requester.
REQ-013 err  output  1  high in the same cycle as done only when the transfer was aborted by timeout.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE and WAIT_ACK only; all outputs registered.
REQ-016 IDLE with any req bit high at cycle t: SHALL select a winner round-robin, starting at (last_grant+1) mod NUM_REQ and scanning upward with wrap.
REQ-017 On selection, at t+1: sync_en=1 for exactly one cycle, sync_data=winner's req_data sampled at t, sync_id=winner, state=WAIT_ACK, last_grant=winner.
REQ-018 sync_data and sync_id SHALL hold stable from launch until the cycle after transfer completion; later changes on req_data SHALL be ignored.
REQ-019 In WAIT_ACK, a wait counter SHALL start at 0 on the launch cycle and increment every cycle.
REQ-020 sync_ack high in WAIT_ACK at cycle t: at t+1 done[sync_id]=1, err=0, state=IDLE.
REQ-021 Counter reaching TIMEOUT-1 with no ack at cycle t: at t+1 done[sync_id]=1, err=1, state=IDLE.
REQ-022 Ack and timeout in the same cycle: ack SHALL win (err=0).
REQ-023 sync_ack while IDLE SHALL be ignored; no output change.
REQ-024 Deassertion of the owner's req during WAIT_ACK SHALL NOT abort the transfer; done still pulses.
REQ-025 The done cycle is spent in IDLE; a pending req sampled then SHALL launch on the next cycle (min launch spacing = ack-to-launch of 2 cycles).
REQ-026 A requester whose req is still high in its own done cycle SHALL NOT be treated as a new request that cycle; selection resumes the cycle after.
REQ-027 Any number of simultaneous req bits SHALL produce exactly one launch; no requester starved beyond NUM_REQ-1 intervening transfers.

Reset
REQ-028 rst high SHALL force state=IDLE, sync_en=0, sync_data=0, sync_id=0, done=0, err=0, busy=0, counter=0, last_grant=NUM_REQ-1 (requester 0 first priority).
REQ-029 rst during WAIT_ACK SHALL abandon the transfer without a done pulse; a later stray sync_ack SHALL be ignored per REQ-023.

Verification
REQ-030 Single: req[2]=1, data 16'hBEEF at t -> t+1 sync_en=1, sync_data=BEEF, sync_id=2; ack at t+5 -> t+6 done=4'b0100, err=0, busy=0.
REQ-031 Contention: req=4'b1111 held, immediate acks -> launch order 0,1,2,3,0; each launch 2 cycles after preceding ack.
REQ-032 Timeout: TIMEOUT=8, req[1] high, no ack -> done=4'b0010, err=1 exactly 8 cycles after launch; then state IDLE.
REQ-033 Race: ack coincident with final timeout cycle -> done pulse with err=0.
REQ-034 Data hold: change req_data[0] and drop req[0] mid-WAIT_ACK -> sync_data unchanged, done[0] still pulses on ack.
REQ-035 Reset mid-transfer: rst during WAIT_ACK, then ack -> no done pulse, all outputs at reset values, next req launches normally with requester 0 priority.
